serial_frame_tx: RTL and testbench



---
 rtl/serial_pkg.sv | 23 ++
 rtl/serial_bit_timer.sv | 32 +++
 rtl/serial_frame_tx.sv | 158 +++++++++++++++
 tb/tb_serial_frame_tx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encodings and line levels for the serial transmit/receive pair
package serial_pkg;

    // Frame FSM states; the receive side decodes the same encoding.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Line levels seen on the single-wire serial stream.
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// rtl/serial_bit_timer.sv - bit-period timer, ticks on the last cycle of each serial bit
module serial_bit_timer
    import serial_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = cnt_width(BIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] count;

    // The tick is only meaningful while a frame is running.
    assign tick = run && (count == LAST);

    // Count 0..BIT_CYCLES-1 while running; hold at zero when stopped.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - framed LSB-first serial transmitter; SERIAL_FRAME_TX_PARITY_EN adds an even-parity bit
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              done
);

    localparam int IW = cnt_width(DATA_W);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [IW-1:0]     bit_idx;
    logic [IW-1:0]     bit_idx_next;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic [DATA_W-1:0] shreg_shift;
    logic              serial_out_next;
    logic              tx_ready_next;
    logic              busy_next;
    logic              done_next;
    logic              tick;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic              parity_q;
    logic              parity_next;
`endif

    // The next data bit is always the LSB of the word shifted by one.
    assign shreg_shift = shreg >> 1;

    serial_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .run (state != IDLE),
        .tick(tick)
    );

    // State and registered outputs; every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            serial_out <= LINE_IDLE;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            bit_idx    <= bit_idx_next;
            shreg      <= shreg_next;
            serial_out <= serial_out_next;
            tx_ready   <= tx_ready_next;
            busy       <= busy_next;
            done       <= done_next;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q   <= parity_next;
`endif
        end
    end

    // Next state plus the line level of the bit that the next state drives.
    always_comb begin
        state_next      = state;
        bit_idx_next    = bit_idx;
        shreg_next      = shreg;
        serial_out_next = serial_out;
        tx_ready_next   = tx_ready;
        busy_next       = busy;
        done_next       = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        parity_next     = parity_q;
`endif
        case (state)
            IDLE: begin
                serial_out_next = LINE_IDLE;
                tx_ready_next   = 1'b1;
                busy_next       = 1'b0;
                bit_idx_next    = '0;
                if (tx_valid && tx_ready) begin
                    shreg_next      = tx_data;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    parity_next     = ^tx_data;
`endif
                    state_next      = START;
                    tx_ready_next   = 1'b0;
                    busy_next       = 1'b1;
                    serial_out_next = START_BIT;
                end
            end
            START: begin
                if (tick) begin
                    state_next      = DATA;
                    bit_idx_next    = '0;
                    serial_out_next = shreg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_BIT) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state_next      = PARITY;
                        serial_out_next = parity_q;
`else
                        state_next      = STOP;
                        serial_out_next = STOP_BIT;
`endif
                    end else begin
                        bit_idx_next    = bit_idx + IW'(1);
                        shreg_next      = shreg_shift;
                        serial_out_next = shreg_shift[0];
                    end
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_next      = STOP;
                    serial_out_next = STOP_BIT;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_next      = IDLE;
                    serial_out_next = LINE_IDLE;
                    tx_ready_next   = 1'b1;
                    busy_next       = 1'b0;
                    done_next       = 1'b1;
                end
            end
            default: begin
                state_next      = IDLE;
                bit_idx_next    = '0;
                serial_out_next = LINE_IDLE;
                tx_ready_next   = 1'b1;
                busy_next       = 1'b0;
                done_next       = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - scoreboard bench for serial_frame_tx at BIT_CYCLES=4 and BIT_CYCLES=1
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld [2];
    logic [7:0] dat [2];
    logic       rdy [2];
    logic       so  [2];
    logic       bsy [2];
    logic       dn  [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Per-cycle expected line levels of the frame in flight, one queue per instance.
    bit line_q [2][$];
    bit exp_done [2];
    int acc_cnt [2];
    int done_seen [2];
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .tx_data(dat[0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .serial_out(so[0]), .busy(bsy[0]), .done(dn[0])
    );

    serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .tx_data(dat[1]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .serial_out(so[1]), .busy(bsy[1]), .done(dn[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line levels for one whole frame of word w.
    function automatic void build_frame(input int i, input logic [7:0] w);
        int bc;
        bc = (i == 0) ? 4 : 1;
        for (int k = 0; k < bc; k++) line_q[i].push_back(1'b0);
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < bc; k++) line_q[i].push_back(w[b]);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        for (int k = 0; k < bc; k++) line_q[i].push_back(^w);
`endif
        for (int k = 0; k < bc; k++) line_q[i].push_back(1'b1);
    endfunction

    // Reference: a frame occupies the line for its queued cycles; a word is taken only when the queue is empty.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit was;
            if (rst) begin
                line_q[i].delete();
                exp_done[i] = 1'b0;
            end else begin
                was = (line_q[i].size() != 0);
                if (was) void'(line_q[i].pop_front());
                exp_done[i] = was && (line_q[i].size() == 0);
                if (!was && vld[i] === 1'b1) begin
                    build_frame(i, dat[i]);
                    acc_cnt[i]++;
                end
            end
        end
    end

    // Compare every output of both instances once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                logic e_so;
                e_so = (line_q[i].size() != 0) ? line_q[i][0] : 1'b1;
                check($sformatf("serial_out[%0d]", i), so[i], e_so);
                check($sformatf("tx_ready[%0d]", i), rdy[i], line_q[i].size() == 0);
                check($sformatf("busy[%0d]", i), bsy[i], line_q[i].size() != 0);
                check($sformatf("done[%0d]", i), dn[i], exp_done[i]);
                if (dn[i] === 1'b1) done_seen[i]++;
            end
        end
    end

    task automatic wait_idle(input int i, input int budget);
        int n;
        n = 0;
        while (line_q[i].size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (line_q[i].size() != 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL wait_idle[%0d] observed=busy expected=idle within %0d cycles", i, budget);
        end
    endtask

    task automatic send(input int i, input logic [7:0] w);
        wait_idle(i, 200);
        vld[i] = 1'b1;
        dat[i] = w;
        @(negedge clk);
        vld[i] = 1'b0;
    endtask

    initial begin
        int a;
        int d;
        int n;
        rst = 1'b1;
        vld[0] = 1'b0; vld[1] = 1'b0;
        dat[0] = 8'h00; dat[1] = 8'h00;
        acc_cnt[0] = 0; acc_cnt[1] = 0;
        done_seen[0] = 0; done_seen[1] = 0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frames: 0xA5, then 0x01 (differing parity when enabled)
        send(0, 8'hA5);
        wait_idle(0, 100);
        repeat (3) @(negedge clk);
        send(0, 8'h01);
        wait_idle(0, 100);
        repeat (2) @(negedge clk);

        // Back-to-back with tx_valid held: 0x00 then 0xFF
        d = done_seen[0];
        a = acc_cnt[0];
        vld[0] = 1'b1;
        dat[0] = 8'h00;
        n = 0;
        while (acc_cnt[0] == a && n < 100) begin @(negedge clk); n++; end
        dat[0] = 8'hFF;
        n = 0;
        while (acc_cnt[0] < a + 2 && n < 100) begin @(negedge clk); n++; end
        vld[0] = 1'b0;
        wait_idle(0, 100);
        repeat (3) @(negedge clk);
        check("b2b_done_pulses", done_seen[0] - d, 2);

        // Input changes mid-frame are ignored
        d = done_seen[0];
        send(0, 8'h3C);
        repeat (10) @(negedge clk);
        dat[0] = 8'hFF;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        wait_idle(0, 100);
        repeat (10) @(negedge clk);
        check("midframe_done_pulses", done_seen[0] - d, 1);

        // Reset during DATA abandons the frame without a done pulse
        d = done_seen[0];
        send(0, 8'h5A);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_no_done", done_seen[0] - d, 0);
        send(0, 8'hC3);
        wait_idle(0, 100);
        repeat (3) @(negedge clk);
        check("after_rst_done", done_seen[0] - d, 1);

        // One cycle per bit
        d = done_seen[1];
        send(1, 8'h80);
        wait_idle(1, 50);
        send(1, 8'h3C);
        wait_idle(1, 50);
        repeat (3) @(negedge clk);
        check("bc1_done_pulses", done_seen[1] - d, 2);
        check("total_done0", done_seen[0], 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
